// File: rtl/if_stage_ibuf.sv
// Fetch stage with an in-order instruction buffer on an SRAM-like
// req/addr_ok/data_ok port, keeping up to IBUF_DEPTH fetches in flight.
module if_stage_ibuf #(
  parameter logic [31:0] RESET_PC   = 32'hbfc00000,
  parameter logic [31:0] EX_ENTRY   = 32'hbfc00380,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        eret_flush,
  input  logic [31:0] cp0_epc,
  input  logic        ws_ex,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);
  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int DW = $clog2(IBUF_DEPTH + 1) + 1;
  localparam logic [PW:0]   PTR_ONE = (PW+1)'(1'b1);
  localparam logic [PW:0]   PTR_ZERO = {(PW+1){1'b0}};
  localparam logic [DW-1:0] DEPTH_D = DW'(IBUF_DEPTH);

  logic              req_r;
  logic [31:0]       addr_r;
  logic [31:0]       fetch_pc_r;
  logic              stale_r;
  logic [PW:0]       head_r;
  logic [PW:0]       fill_r;
  logic [PW:0]       tail_r;
  logic [DW-1:0]     discard_r;
  logic [31:0]       slot_pc_r   [IBUF_DEPTH];
  logic [31:0]       slot_inst_r [IBUF_DEPTH];
  logic [IBUF_DEPTH-1:0] slot_filled_r;

  logic              redirect_s;
  logic [31:0]       new_pc_s;
  logic              accept_s;
  logic              keep_s;
  logic              drop_s;
  logic [PW:0]       count_s;
  logic [PW:0]       inflight_s;
  logic [PW:0]       used_after_s;
  logic              room_after_s;
  logic              issue_s;
  logic              valid_s;
  logic              pop_s;
  logic [DW-1:0]     disc_nxt_s;
  logic [PW-1:0]     head_idx_s;
  logic [PW-1:0]     fill_idx_s;
  logic [PW-1:0]     tail_idx_s;

  // Redirect selection, handshakes, occupancy and discard bookkeeping
  always_comb begin
    redirect_s = ws_ex | eret_flush | br_taken;
    if (ws_ex) begin
      new_pc_s = EX_ENTRY;
    end else if (eret_flush) begin
      new_pc_s = cp0_epc;
    end else if (br_taken) begin
      new_pc_s = br_target;
    end else begin
      new_pc_s = fetch_pc_r;
    end
    head_idx_s   = head_r[PW-1:0];
    fill_idx_s   = fill_r[PW-1:0];
    tail_idx_s   = tail_r[PW-1:0];
    accept_s     = req_r & inst_sram_addr_ok;
    drop_s       = inst_sram_data_ok & (discard_r != {DW{1'b0}});
    keep_s       = inst_sram_data_ok & (discard_r == {DW{1'b0}});
    count_s      = tail_r - head_r;
    inflight_s   = tail_r - fill_r;
    valid_s      = slot_filled_r[head_idx_s] & (head_r != tail_r) & ~redirect_s;
    pop_s        = valid_s & ds_allowin;
    used_after_s = tail_r + PTR_ONE - head_r - {{PW{1'b0}}, pop_s};
    // Responses still owed to the discard counter occupy slots too, which
    // bounds the total number of fetches the memory can owe us.
    room_after_s = (DW'(used_after_s) + discard_r) < DEPTH_D;
    issue_s      = ~req_r & ((DW'(count_s) + discard_r) < DEPTH_D);
    // On a redirect every kept in-flight response becomes a discard, minus one
    // if it lands this very cycle, plus the request accepted this cycle.
    if (redirect_s) begin
      disc_nxt_s = discard_r + DW'(inflight_s) + DW'(accept_s) - DW'(keep_s) - DW'(drop_s);
    end else begin
      disc_nxt_s = discard_r + DW'(stale_r & accept_s) - DW'(drop_s);
    end
  end

  // Request, pointers, stale marker and discard counter
  always_ff @(posedge clk) begin
    if (reset) begin
      req_r         <= 1'b0;
      addr_r        <= RESET_PC;
      fetch_pc_r    <= RESET_PC;
      stale_r       <= 1'b0;
      head_r        <= PTR_ZERO;
      fill_r        <= PTR_ZERO;
      tail_r        <= PTR_ZERO;
      discard_r     <= {DW{1'b0}};
      slot_filled_r <= {IBUF_DEPTH{1'b0}};
    end else begin
      discard_r <= disc_nxt_s;
      if (redirect_s) begin
        head_r     <= PTR_ZERO;
        fill_r     <= PTR_ZERO;
        tail_r     <= PTR_ZERO;
        fetch_pc_r <= new_pc_s;
        if (req_r & ~inst_sram_addr_ok) begin
          stale_r <= 1'b1;
        end else begin
          req_r   <= 1'b0;
          stale_r <= 1'b0;
        end
      end else begin
        if (pop_s) begin
          head_r <= head_r + PTR_ONE;
        end
        if (keep_s) begin
          slot_filled_r[fill_idx_s] <= 1'b1;
          fill_r                    <= fill_r + PTR_ONE;
        end
        if (accept_s && stale_r) begin
          req_r   <= 1'b0;
          stale_r <= 1'b0;
        end else if (accept_s) begin
          slot_filled_r[tail_idx_s] <= 1'b0;
          tail_r     <= tail_r + PTR_ONE;
          fetch_pc_r <= addr_r + 32'd4;
          addr_r     <= addr_r + 32'd4;
          req_r      <= room_after_s;
        end else if (issue_s) begin
          req_r  <= 1'b1;
          addr_r <= fetch_pc_r;
        end
      end
    end
  end

  // Slot payloads; qualified by pointers and filled bits so no reset needed
  always_ff @(posedge clk) begin
    if (!redirect_s && accept_s && !stale_r) begin
      slot_pc_r[tail_idx_s] <= addr_r;
    end
    if (!redirect_s && keep_s) begin
      slot_inst_r[fill_idx_s] <= inst_sram_rdata;
    end
  end

  assign fs_to_ds_valid  = valid_s;
  assign fs_to_ds_bus    = {slot_inst_r[head_idx_s], slot_pc_r[head_idx_s]};
  assign inst_sram_req   = req_r;
  assign inst_sram_addr  = addr_r;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0000_0000;

endmodule
